kb_field_editor: RTL and testbench

- Parametrised successor to the keyboard edit controller. Consumes raw PS/2 scan-code bytes from the keyboard receiver.
- Decodes make/break/extended prefixes and suppresses typematic repeats.
- Runs an edit session over groups of BCD fields (clock, date, timer) and presents one address/data pair to the processor with a commit/acknowledge handshake.
- Sits between the PS/2 receiver and the processor's input port mux.

---
 rtl/kb_field_editor.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_kb_field_editor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kb_field_editor.sv
// kb_field_editor
//    Decodes raw PS/2 scan-code bytes (make / break / extended prefixes) and
//    suppresses typematic repeats. Runs an edit session over groups of BCD
//    fields and offers one address/data pair to the processor. The pair is
//    handed over with a commit/acknowledge handshake.
//
// Ports
//    CLK         system clock
//    RESET       asynchronous, active-high reset
//    scan_code   scan-code byte from the PS/2 receiver
//    scan_valid  one-cycle strobe, scan_code valid this cycle
//    commit_ack  processor read strobe, consumes a pending commit
//    address     target register address
//    data        packed BCD value, most significant digit in the upper nibble
//    commit      high while address/data wait for the processor
//    mode        0 = IDLE, 1 = EDIT, 2 = COMMIT
//    cursor      current field index within the selected group
module kb_field_editor #(
   parameter int ADDR_W      = 8,
   parameter int DIGITS      = 2,
   parameter int FIELDS      = 3,
   parameter int CLOCK_BASE  = 0,
   parameter int DATE_BASE   = 3,
   parameter int TIMER_BASE  = 6,
   parameter int RING_ADDR   = 10,
   parameter int TOGGLE_ADDR = 11
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [7:0]                scan_code,
   input  logic                      scan_valid,
   input  logic                      commit_ack,
   output logic [ADDR_W-1:0]         address,
   output logic [4*DIGITS-1:0]       data,
   output logic                      commit,
   output logic [1:0]                mode,
   output logic [$clog2(FIELDS)-1:0] cursor
);

   localparam int DW   = 4 * DIGITS;
   localparam int CW   = $clog2(FIELDS);
   localparam int CNTW = $clog2(DIGITS + 1);

   localparam logic [7:0] KEY_BRK   = 8'hF0;
   localparam logic [7:0] KEY_EXT   = 8'hE0;
   localparam logic [7:0] KEY_F1    = 8'h05;
   localparam logic [7:0] KEY_F2    = 8'h06;
   localparam logic [7:0] KEY_F3    = 8'h04;
   localparam logic [7:0] KEY_F11   = 8'h78;
   localparam logic [7:0] KEY_F12   = 8'h07;
   localparam logic [7:0] KEY_TAB   = 8'h0D;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_ESC   = 8'h76;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Maps a digit scan code to {hit, value}; hit is clear for non-digit codes.
   function automatic logic [4:0] digit_of(input logic [7:0] code);
      logic [4:0] res;
      case (code)
         8'h45:   res = {1'b1, 4'd0};
         8'h16:   res = {1'b1, 4'd1};
         8'h1E:   res = {1'b1, 4'd2};
         8'h26:   res = {1'b1, 4'd3};
         8'h25:   res = {1'b1, 4'd4};
         8'h2E:   res = {1'b1, 4'd5};
         8'h36:   res = {1'b1, 4'd6};
         8'h3D:   res = {1'b1, 4'd7};
         8'h3E:   res = {1'b1, 4'd8};
         8'h46:   res = {1'b1, 4'd9};
         default: res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [ADDR_W-1:0] address_r, address_nxt_s;
   logic [ADDR_W-1:0] base_r, base_nxt_s;
   logic [DW-1:0]     data_r, data_nxt_s;
   logic              commit_r, commit_nxt_s;
   logic [CW-1:0]     cursor_r, cursor_nxt_s;
   logic [CNTW-1:0]   count_r, count_nxt_s;
   logic              brk_r, brk_nxt_s;
   logic              ext_r, ext_nxt_s;
   logic [7:0]        last_make_r, last_make_nxt_s;

   logic              key_ev_s;
   logic              act_s;
   logic              grp_hit_s;
   logic [ADDR_W-1:0] grp_base_s;
   logic [4:0]        dig_s;
   logic [CW-1:0]     cur_tab_s;

   // Prefix tracking, repeat filtering and key-group decode.
   always_comb begin
      brk_nxt_s       = brk_r;
      ext_nxt_s       = ext_r;
      last_make_nxt_s = last_make_r;
      act_s           = 1'b0;
      key_ev_s        = scan_valid && (scan_code != KEY_BRK) && (scan_code != KEY_EXT);

      if (scan_valid) begin
         if (scan_code == KEY_BRK) begin
            brk_nxt_s = 1'b1;
         end else if (scan_code == KEY_EXT) begin
            ext_nxt_s = 1'b1;
         end else begin
            brk_nxt_s = 1'b0;
            ext_nxt_s = 1'b0;
         end
      end else begin
         brk_nxt_s = brk_r;
      end

      // Extended events never touch last_make; a break only releases the
      // key that is currently held.
      if (key_ev_s && !ext_r) begin
         if (brk_r) begin
            if (scan_code == last_make_r) begin
               last_make_nxt_s = 8'h00;
            end else begin
               last_make_nxt_s = last_make_r;
            end
         end else if (scan_code != last_make_r) begin
            last_make_nxt_s = scan_code;
            act_s           = 1'b1;
         end else begin
            act_s = 1'b0;
         end
      end else begin
         act_s = 1'b0;
      end

      case (scan_code)
         KEY_F1: begin
            grp_hit_s  = 1'b1;
            grp_base_s = ADDR_W'(DATE_BASE);
         end
         KEY_F2: begin
            grp_hit_s  = 1'b1;
            grp_base_s = ADDR_W'(CLOCK_BASE);
         end
         KEY_F3: begin
            grp_hit_s  = 1'b1;
            grp_base_s = ADDR_W'(TIMER_BASE);
         end
         default: begin
            grp_hit_s  = 1'b0;
            grp_base_s = {ADDR_W{1'b0}};
         end
      endcase

      dig_s = digit_of(scan_code);

      if (cursor_r == CW'(FIELDS - 1)) begin
         cur_tab_s = {CW{1'b0}};
      end else begin
         cur_tab_s = cursor_r + CW'(1);
      end
   end

   // Edit-session next state and next output values.
   always_comb begin
      state_nxt_s   = state_r;
      address_nxt_s = address_r;
      base_nxt_s    = base_r;
      data_nxt_s    = data_r;
      cursor_nxt_s  = cursor_r;
      count_nxt_s   = count_r;

      case (state_r)
         ST_IDLE: begin
            if (act_s && grp_hit_s) begin
               state_nxt_s   = ST_EDIT;
               base_nxt_s    = grp_base_s;
               address_nxt_s = grp_base_s;
               cursor_nxt_s  = {CW{1'b0}};
               data_nxt_s    = {DW{1'b0}};
               count_nxt_s   = {CNTW{1'b0}};
            end else if (act_s && (scan_code == KEY_F11)) begin
               state_nxt_s   = ST_COMMIT;
               address_nxt_s = ADDR_W'(TOGGLE_ADDR);
               data_nxt_s    = DW'(1);
            end else if (act_s && (scan_code == KEY_F12)) begin
               state_nxt_s   = ST_COMMIT;
               address_nxt_s = ADDR_W'(RING_ADDR);
               data_nxt_s    = {DW{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_EDIT: begin
            if (!act_s) begin
               state_nxt_s = ST_EDIT;
            end else if (grp_hit_s) begin
               base_nxt_s    = grp_base_s;
               address_nxt_s = grp_base_s;
               cursor_nxt_s  = {CW{1'b0}};
               data_nxt_s    = {DW{1'b0}};
               count_nxt_s   = {CNTW{1'b0}};
            end else if (dig_s[4]) begin
               // Shifting left naturally drops the oldest digit off the top.
               data_nxt_s = (data_r << 4) | DW'(dig_s[3:0]);
               if (count_r != CNTW'(DIGITS)) begin
                  count_nxt_s = count_r + CNTW'(1);
               end else begin
                  count_nxt_s = count_r;
               end
            end else if (scan_code == KEY_TAB) begin
               cursor_nxt_s  = cur_tab_s;
               address_nxt_s = base_r + ADDR_W'(cur_tab_s);
               data_nxt_s    = {DW{1'b0}};
               count_nxt_s   = {CNTW{1'b0}};
            end else if ((scan_code == KEY_ENTER) && (count_r != {CNTW{1'b0}})) begin
               state_nxt_s = ST_COMMIT;
            end else if (scan_code == KEY_ESC) begin
               state_nxt_s   = ST_IDLE;
               address_nxt_s = {ADDR_W{1'b0}};
               base_nxt_s    = {ADDR_W{1'b0}};
               data_nxt_s    = {DW{1'b0}};
               cursor_nxt_s  = {CW{1'b0}};
               count_nxt_s   = {CNTW{1'b0}};
            end else begin
               state_nxt_s = ST_EDIT;
            end
         end

         ST_COMMIT: begin
            // Keys are ignored here, so an ack always wins over a key byte.
            if (commit_ack) begin
               state_nxt_s   = ST_IDLE;
               address_nxt_s = {ADDR_W{1'b0}};
               base_nxt_s    = {ADDR_W{1'b0}};
               data_nxt_s    = {DW{1'b0}};
               cursor_nxt_s  = {CW{1'b0}};
               count_nxt_s   = {CNTW{1'b0}};
            end else begin
               state_nxt_s = ST_COMMIT;
            end
         end

         default: begin
            state_nxt_s   = ST_IDLE;
            address_nxt_s = {ADDR_W{1'b0}};
            base_nxt_s    = {ADDR_W{1'b0}};
            data_nxt_s    = {DW{1'b0}};
            cursor_nxt_s  = {CW{1'b0}};
            count_nxt_s   = {CNTW{1'b0}};
         end
      endcase

      commit_nxt_s = (state_nxt_s == ST_COMMIT);
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r     <= ST_IDLE;
         address_r   <= {ADDR_W{1'b0}};
         base_r      <= {ADDR_W{1'b0}};
         data_r      <= {DW{1'b0}};
         commit_r    <= 1'b0;
         cursor_r    <= {CW{1'b0}};
         count_r     <= {CNTW{1'b0}};
         brk_r       <= 1'b0;
         ext_r       <= 1'b0;
         last_make_r <= 8'h00;
      end else begin
         state_r     <= state_nxt_s;
         address_r   <= address_nxt_s;
         base_r      <= base_nxt_s;
         data_r      <= data_nxt_s;
         commit_r    <= commit_nxt_s;
         cursor_r    <= cursor_nxt_s;
         count_r     <= count_nxt_s;
         brk_r       <= brk_nxt_s;
         ext_r       <= ext_nxt_s;
         last_make_r <= last_make_nxt_s;
      end
   end

   assign address = address_r;
   assign data    = data_r;
   assign commit  = commit_r;
   assign mode    = state_r;
   assign cursor  = cursor_r;

endmodule

// File: tb/tb_kb_field_editor.sv
// tb_kb_field_editor
//    Directed bench for kb_field_editor with default parameters. Inputs are
//    driven and outputs sampled on the falling clock edge.
module tb_kb_field_editor;

   logic       CLK;
   logic       RESET;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       commit_ack;
   logic [7:0] address;
   logic [7:0] data;
   logic       commit;
   logic [1:0] mode;
   logic [1:0] cursor;

   int pass_cnt  = 0;
   int total_cnt = 0;

   kb_field_editor dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .commit_ack (commit_ack),
      .address    (address),
      .data       (data),
      .commit     (commit),
      .mode       (mode),
      .cursor     (cursor)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One byte for one clock; outputs are valid on return.
   task automatic send(input logic [7:0] b);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge CLK);
      scan_valid = 1'b0;
   endtask

   task automatic release_key(input logic [7:0] b);
      send(8'hF0);
      send(b);
   endtask

   task automatic press(input logic [7:0] b);
      send(b);
      release_key(b);
   endtask

   task automatic ack;
      commit_ack = 1'b1;
      @(negedge CLK);
      commit_ack = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_addr"},   32'(address), 32'h0);
      check({tag, "_data"},   32'(data),    32'h0);
      check({tag, "_commit"}, 32'(commit),  32'h0);
      check({tag, "_mode"},   32'(mode),    32'h0);
      check({tag, "_cursor"}, 32'(cursor),  32'h0);
   endtask

   initial begin
      RESET      = 1'b1;
      scan_code  = 8'h00;
      scan_valid = 1'b0;
      commit_ack = 1'b0;
      repeat (2) @(negedge CLK);
      check_idle("reset");
      RESET = 1'b0;
      @(negedge CLK);

      // Reset mid-edit after F1, 1, 2.
      press(8'h05);
      check("f1_addr", 32'(address), 32'h3);
      check("f1_mode", 32'(mode), 32'h1);
      press(8'h16);
      press(8'h1E);
      check("f1_data12", 32'(data), 32'h12);
      RESET = 1'b1;
      @(negedge CLK);
      check_idle("mid_reset");
      RESET = 1'b0;
      @(negedge CLK);

      // F2, digits 1 2 3, Enter, ack.
      press(8'h06);
      press(8'h16);
      press(8'h1E);
      press(8'h26);
      check("f2_data23", 32'(data), 32'h23);
      send(8'h5A);
      check("f2_commit_addr", 32'(address), 32'h0);
      check("f2_commit_data", 32'(data), 32'h23);
      check("f2_commit", 32'(commit), 32'h1);
      check("f2_mode", 32'(mode), 32'h2);
      release_key(8'h5A);
      check("f2_hold_data", 32'(data), 32'h23);
      ack;
      check_idle("f2_ack");

      // F1 then Tab three times, then Enter with no digits.
      press(8'h05);
      check("tab0_addr", 32'(address), 32'h3);
      send(8'h0D);
      check("tab1_addr", 32'(address), 32'h4);
      check("tab1_cur", 32'(cursor), 32'h1);
      release_key(8'h0D);
      send(8'h0D);
      check("tab2_addr", 32'(address), 32'h5);
      check("tab2_cur", 32'(cursor), 32'h2);
      release_key(8'h0D);
      send(8'h0D);
      check("tab3_addr", 32'(address), 32'h3);
      check("tab3_cur", 32'(cursor), 32'h0);
      release_key(8'h0D);
      press(8'h5A);
      check("enter0_mode", 32'(mode), 32'h1);
      check("enter0_commit", 32'(commit), 32'h0);

      // F3, digit 5 held with repeats, released and pressed again.
      press(8'h04);
      check("f3_addr", 32'(address), 32'h6);
      send(8'h2E);
      send(8'h2E);
      send(8'h2E);
      check("rep_data", 32'(data), 32'h05);
      release_key(8'h2E);
      send(8'h2E);
      check("rep2_data", 32'(data), 32'h55);
      release_key(8'h2E);
      press(8'h5A);
      check("f3_commit_addr", 32'(address), 32'h6);
      check("f3_commit_data", 32'(data), 32'h55);
      check("f3_commit", 32'(commit), 32'h1);
      ack;
      check_idle("f3_ack");

      // F12 in IDLE; key during COMMIT; ack together with a key byte.
      press(8'h07);
      check("f12_addr", 32'(address), 32'hA);
      check("f12_data", 32'(data), 32'h0);
      check("f12_commit", 32'(commit), 32'h1);
      send(8'h16);
      check("cmt_key_data", 32'(data), 32'h0);
      check("cmt_key_addr", 32'(address), 32'hA);
      release_key(8'h16);
      scan_code  = 8'h05;
      scan_valid = 1'b1;
      commit_ack = 1'b1;
      @(negedge CLK);
      scan_valid = 1'b0;
      commit_ack = 1'b0;
      check_idle("ack_key");
      // F1 is still held from the discarded byte, so this make is a repeat.
      send(8'h05);
      check("ack_key_rep_mode", 32'(mode), 32'h0);
      release_key(8'h05);

      // F11 in IDLE.
      press(8'h78);
      check("f11_addr", 32'(address), 32'hB);
      check("f11_data", 32'(data), 32'h01);
      check("f11_mode", 32'(mode), 32'h2);
      ack;
      check("f11_ack_mode", 32'(mode), 32'h0);

      // Extended Enter ignored, stray ack ignored, Esc clears.
      press(8'h06);
      press(8'h16);
      send(8'hE0);
      send(8'h5A);
      check("ext_mode", 32'(mode), 32'h1);
      check("ext_commit", 32'(commit), 32'h0);
      send(8'hE0);
      send(8'hF0);
      send(8'h5A);
      ack;
      check("stray_ack_mode", 32'(mode), 32'h1);
      check("stray_ack_data", 32'(data), 32'h01);
      send(8'h76);
      check_idle("esc");
      release_key(8'h76);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
